// File: rtl/seg_pkg.sv
// Seven-segment scan controller shared definitions.
// Digit geometry, default prescaler widths and the frame bundle.
package seg_pkg;

  localparam int NUM_DIGITS     = 8;
  localparam int NIB_W          = 4;
  localparam int DATA_W         = NUM_DIGITS * NIB_W;
  localparam int DIV_BITS_DEF   = 17;
  localparam int BLINK_BITS_DEF = 26;
  localparam int SCAN_W         = $clog2(NUM_DIGITS);

  // Index of the rightmost digit; scan wraps after it.
  localparam logic [SCAN_W-1:0] LAST_DIGIT = SCAN_W'(NUM_DIGITS - 1);

  // One complete display image.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] les;
    logic [NUM_DIGITS-1:0] point;
    logic [NUM_DIGITS-1:0] blink;
  } seg_frame_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler.
// Pulses tick for one cycle while the count is all-ones.
module seg_tick_gen #(
  parameter int WIDTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [WIDTH-1:0] r_cnt;

  // Wrapping counter, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + WIDTH'(1);
  end

  assign tick = &r_cnt;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan and tear-free update buffer for an 8-digit display.
// Updates land in a shadow buffer and commit only at frame end.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_BITS   = DIV_BITS_DEF,
  parameter int BLINK_BITS = BLINK_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [NUM_DIGITS-1:0] wr_les,
  input  logic [NUM_DIGITS-1:0] wr_point,
  input  logic [NUM_DIGITS-1:0] wr_blink,
  output logic [SCAN_W-1:0]     scan,
  output logic [DATA_W-1:0]     data,
  output logic [NUM_DIGITS-1:0] les,
  output logic [NUM_DIGITS-1:0] point,
  output logic                  flash
);

  logic w_scan_tick;
  logic w_blink_tick;
  logic w_frame_end;
  logic w_accept;
  logic w_commit;
  logic w_flash_nxt;

  seg_frame_t w_commit_nxt;

  logic [SCAN_W-1:0]     r_scan;
  logic                  r_pending;
  logic                  r_flash;
  logic [NUM_DIGITS-1:0] r_les;
  seg_frame_t            r_shadow;
  seg_frame_t            r_commit;

  seg_tick_gen #(.WIDTH(DIV_BITS)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_scan_tick)
  );

  seg_tick_gen #(.WIDTH(BLINK_BITS)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_blink_tick)
  );

  assign wr_ready    = ~r_pending;
  assign w_accept    = wr_valid & ~r_pending;
  assign w_frame_end = w_scan_tick & (r_scan == LAST_DIGIT);
  assign w_commit    = w_frame_end & r_pending;
  assign w_flash_nxt = r_flash ^ w_blink_tick;

  // Next committed image, so les can follow it on the same edge.
  always_comb begin
    w_commit_nxt = r_commit;
    if (w_commit) w_commit_nxt = r_shadow;
  end

  // Digit scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_scan <= '0;
    else if (w_scan_tick) r_scan <= r_scan + SCAN_W'(1);
  end

  // Shadow capture and pending flag; commit always wins the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_shadow  <= '0;
    end else if (w_commit) begin
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pending      <= 1'b1;
      r_shadow.data  <= wr_data;
      r_shadow.les   <= wr_les;
      r_shadow.point <= wr_point;
      r_shadow.blink <= wr_blink;
    end
  end

  // Committed image, only replaced at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_commit <= '0;
    else        r_commit <= w_commit_nxt;
  end

  // Blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flash <= 1'b0;
    else        r_flash <= w_flash_nxt;
  end

  // Effective enables with blanking applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_les <= '0;
    else        r_les <= w_commit_nxt.les &
                         ~(w_commit_nxt.blink & {NUM_DIGITS{w_flash_nxt}});
  end

  assign scan  = r_scan;
  assign data  = r_commit.data;
  assign point = r_commit.point;
  assign les   = r_les;
  assign flash = r_flash;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV_BITS=2, BLINK_BITS=4.
// Frame = 32 cycles, flash toggles every 16 cycles.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [7:0]  wr_les;
  logic [7:0]  wr_point;
  logic [7:0]  wr_blink;
  logic [2:0]  scan;
  logic [31:0] data;
  logic [7:0]  les;
  logic [7:0]  point;
  logic        flash;

  int n_chk;
  int n_fail;
  int k;

  seg_scan_ctrl #(.DIV_BITS(2), .BLINK_BITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_les   (wr_les),
    .wr_point (wr_point),
    .wr_blink (wr_blink),
    .scan     (scan),
    .data     (data),
    .les      (les),
    .point    (point),
    .flash    (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Advance to 1 time unit after posedge number tgt since reset release.
  task automatic go(input int tgt);
    while (k < tgt) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic [7:0] l,
                    input logic [7:0] p, input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_les   = l;
    wr_point = p;
    wr_blink = b;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    k        = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_les   = '0;
    wr_point = '0;
    wr_blink = '0;

    #12;
    chk("rst_scan", 32'(scan), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_les", 32'(les), 32'd0);
    chk("rst_flash", 32'(flash), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k     = 0;

    // Idle scanning
    go(3);
    chk("scan_k3", 32'(scan), 32'd0);
    go(4);
    chk("scan_k4", 32'(scan), 32'd1);
    go(28);
    chk("scan_k28", 32'(scan), 32'd7);
    go(32);
    chk("scan_wrap", 32'(scan), 32'd0);
    chk("idle_data", data, 32'd0);
    chk("idle_les", 32'(les), 32'd0);
    chk("idle_ready", 32'(wr_ready), 32'd1);
    go(16 + 32);
    chk("flash_k48", 32'(flash), 32'd1);

    // Write while scan=2 (k=64..67 is frame 2, scan 2 at k=72)
    go(72);
    chk("pre_wr_scan", 32'(scan), 32'd2);
    wr(32'h1234_ABCD, 8'hFF, 8'h01, 8'h00);
    go(73);
    wr_valid = 1'b0;
    chk("acc_ready", 32'(wr_ready), 32'd0);
    chk("acc_data_hold", data, 32'd0);
    go(95);
    chk("k95_scan", 32'(scan), 32'd7);
    chk("k95_data_hold", data, 32'd0);
    chk("k95_les_hold", 32'(les), 32'd0);
    go(96);
    chk("c1_scan", 32'(scan), 32'd0);
    chk("c1_data", data, 32'h1234_ABCD);
    chk("c1_les", 32'(les), 32'hFF);
    chk("c1_point", 32'(point), 32'h01);
    chk("c1_ready", 32'(wr_ready), 32'd1);

    // Second request held while pending is ignored
    wr(32'h5555_0000, 8'h0F, 8'h00, 8'h00);
    go(97);
    chk("a2_ready", 32'(wr_ready), 32'd0);
    wr(32'hDEAD_BEEF, 8'hF0, 8'hFF, 8'h00);
    go(127);
    chk("a2_hold", data, 32'h1234_ABCD);
    go(128);
    chk("c2_data", data, 32'h5555_0000);
    chk("c2_les", 32'(les), 32'h0F);
    chk("c2_ready", 32'(wr_ready), 32'd1);
    go(129);
    wr_valid = 1'b0;
    chk("a3_ready", 32'(wr_ready), 32'd0);
    go(159);
    chk("a3_hold", data, 32'h5555_0000);
    go(160);
    chk("c3_data", data, 32'hDEAD_BEEF);
    chk("c3_les", 32'(les), 32'hF0);
    chk("c3_point", 32'(point), 32'hFF);

    // Blink on the leftmost digit
    wr(32'h0000_0000, 8'hFF, 8'h00, 8'h80);
    go(161);
    wr_valid = 1'b0;
    go(192);
    chk("bl_flash0", 32'(flash), 32'd0);
    chk("bl_les_on", 32'(les), 32'hFF);
    go(207);
    chk("bl_les_k207", 32'(les), 32'hFF);
    go(208);
    chk("bl_flash1", 32'(flash), 32'd1);
    chk("bl_les_off", 32'(les), 32'h7F);
    go(223);
    chk("bl_les_k223", 32'(les), 32'h7F);
    go(224);
    chk("bl_les_back", 32'(les), 32'hFF);

    // Accept on the edge just before a frame boundary
    go(254);
    wr(32'hCAFE_F00D, 8'h3C, 8'h0A, 8'h00);
    go(255);
    wr_valid = 1'b0;
    chk("lat_ready", 32'(wr_ready), 32'd0);
    chk("lat_hold", data, 32'h0000_0000);
    go(256);
    chk("lat_data", data, 32'hCAFE_F00D);
    chk("lat_les", 32'(les), 32'h3C);
    chk("lat_point", 32'(point), 32'h0A);
    chk("lat_ready2", 32'(wr_ready), 32'd1);

    // Reset while pending, mid-frame
    wr(32'h1111_1111, 8'hFF, 8'hFF, 8'h00);
    go(257);
    wr_valid = 1'b0;
    chk("pr_ready", 32'(wr_ready), 32'd0);
    go(270);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_data", data, 32'd0);
    chk("ar_les", 32'(les), 32'd0);
    chk("ar_point", 32'(point), 32'd0);
    chk("ar_scan", 32'(scan), 32'd0);
    chk("ar_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k     = 0;
    go(3);
    chk("rr_scan_k3", 32'(scan), 32'd0);
    go(4);
    chk("rr_scan_k4", 32'(scan), 32'd1);
    go(32);
    chk("rr_scan", 32'(scan), 32'd0);
    chk("rr_data", data, 32'd0);
    chk("rr_les", 32'(les), 32'd0);
    chk("rr_ready", 32'(wr_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV_BITS, default 17: scan-tick prescaler width; one tick every 2^DIV_BITS clk cycles.
REQ-002 SHALL have parameter BLINK_BITS, default 26: blink prescaler width; flash toggles every 2^BLINK_BITS clk cycles.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid, input, 1: a display-update request is presented.
REQ-006 SHALL have port wr_ready, output, 1: the update buffer can accept a request.
REQ-007 SHALL have port wr_data, input, 32: eight hex nibbles; bits [31:28] are the leftmost digit.
REQ-008 SHALL have port wr_les, input, 8: per-digit enable; bit 7 is the leftmost digit.
REQ-009 SHALL have port wr_point, input, 8: per-digit decimal point; bit 7 is the leftmost digit.
REQ-010 SHALL have port wr_blink, input, 8: per-digit blink enable.
REQ-011 SHALL have port scan, output, 3: active digit index; 0 is the leftmost digit.
REQ-012 SHALL have port data, output, 32: committed digit nibbles.
REQ-013 SHALL have port les, output, 8: effective digit enables, with blink applied.
REQ-014 SHALL have port point, output, 8: committed decimal points.
REQ-015 SHALL have port flash, output, 1: blink phase; 1 means the blanked phase.

Function
REQ-016 Scan prescaler SHALL be a free-running DIV_BITS counter, 0 to 2^DIV_BITS-1, wrapping; scan_tick is a 1-cycle pulse in the cycle the count equals all-ones.
REQ-017 On each scan_tick, scan SHALL increment modulo 8 (7 -> 0) at the next edge; otherwise it holds.
REQ-018 A frame boundary SHALL be a scan_tick with scan==7.
REQ-019 wr_ready SHALL equal NOT pending, combinationally from a single pending flag register.
REQ-020 On wr_valid&&wr_ready, wr_data/wr_les/wr_point/wr_blink SHALL be captured into shadow registers and pending set at the same edge.
REQ-021 While pending==1, wr_valid SHALL be ignored and shadow registers SHALL hold.
REQ-022 At a frame boundary with pending==1, shadow contents SHALL be copied to the committed data/point/les/blink registers and pending cleared, on the same edge that scan becomes 0.
REQ-023 Committed registers SHALL change only as stated in REQ-022, so a frame is never torn.
REQ-024 An accept and a commit SHALL never occur on the same edge, because wr_ready is low while pending.
REQ-025 Blink prescaler SHALL be a free-running BLINK_BITS counter; flash toggles at the edge after its all-ones count.
REQ-026 Output les SHALL be a register equal to committed_les AND NOT(committed_blink AND {8{flash}}), updated every cycle.
REQ-027 Outputs scan, data, point and flash SHALL be driven directly from registers.
REQ-028 Latency: worst case from accept to visible output is 8*2^DIV_BITS cycles; the minimum is 1 cycle (accept one cycle before a frame boundary).

Reset
REQ-029 Asserting rst_n=0 SHALL immediately clear both prescalers, scan, pending, the shadow registers, committed data/point/les/blink, the les output and flash to 0, so all digits are dark.
REQ-030 Asserting reset mid-operation SHALL discard any pending update; wr_ready is 1 from reset.
REQ-031 After rst_n deasserts, the first scan_tick SHALL occur 2^DIV_BITS cycles later.

Structure
REQ-032 Package seg_pkg SHALL hold NUM_DIGITS=8, the default DIV_BITS and BLINK_BITS, and the nibble-index helper constants.
REQ-033 Sub-module seg_tick_gen (parameter WIDTH; ports clk, rst_n, tick) SHALL implement the prescaler and be instantiated twice, once each for scan and blink.
REQ-034 Outputs scan, data, les, point and flash SHALL connect directly to the Segment display stage of the same names.

Verification (DIV_BITS=2, BLINK_BITS=4)
REQ-035 Reset release, idle -> scan steps 0..7..0 once every 4 cycles; data=0, les=0, wr_ready=1.
REQ-036 Write data=32'h1234_ABCD, les=8'hFF, point=8'h01 while scan=2 -> wr_ready drops next cycle; outputs unchanged until the edge where scan 7->0, then data=32'h1234_ABCD, les=8'hFF, point=8'h01, wr_ready=1.
REQ-037 Second wr_valid held while pending -> ignored; the first value commits; the second is accepted on the cycle after wr_ready returns.
REQ-038 Commit with blink=8'h80 and les=8'hFF -> les alternates between 8'h7F and 8'hFF every 16 cycles, tracking flash.
REQ-039 rst_n pulsed low while pending, mid-frame -> all outputs 0 asynchronously; no commit afterwards; wr_ready=1.
REQ-040 Write issued on the cycle before a frame-boundary tick -> committed on the next edge; 1-cycle latency observed.
